traffic_light: RTL and testbench

- Single-intersection traffic-light controller.
- Cycles Red → Green → Yellow → Red indefinitely, with a programmable dwell time in clock cycles for each phase.
- Standalone leaf block: one clock and one reset in, three one-hot lamp drives out, no handshake.
- Intended to drive lamp drivers or a display/debug harness directly.

---
 rtl/traffic_light_pkg.sv | 35 +++
 rtl/traffic_light_if.sv | 21 ++
 rtl/traffic_light_timer.sv | 24 ++
 rtl/traffic_light.sv | 72 +++++++
 tb/tb_traffic_light.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: phase encodings, default dwell times
// and counter sizing helpers shared by the controller.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } state_t;

  localparam int DEF_RED    = 10;
  localparam int DEF_GREEN  = 8;
  localparam int DEF_YELLOW = 3;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int w;
    w = $clog2(max3(a, b, c));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/traffic_light_if.sv
// traffic_light_if: dwell-timer control bundle.
// master: clear/limit out, done in; slave: the timer.
interface traffic_light_if #(
  parameter int W = 4
);
  logic         clear;
  logic [W-1:0] limit;
  logic         done;

  modport master (
    output clear,
    output limit,
    input  done
  );

  modport slave (
    input  clear,
    input  limit,
    output done
  );
endinterface

// File: rtl/traffic_light_timer.sv
// traffic_light_timer: dwell counter, cleared by clear,
// done when count equals limit. Ports: clk, rst, tmr.
module traffic_light_timer #(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst,
  traffic_light_if.slave  tmr
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (tmr.clear)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

  assign tmr.done = (cnt == tmr.limit);

endmodule

// File: rtl/traffic_light.sv
// traffic_light: Red->Green->Yellow controller with
// per-phase dwell. Ports: clk, rst, Red, Yellow, Green.
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED,
  parameter int GREEN_CYCLES  = DEF_GREEN,
  parameter int YELLOW_CYCLES = DEF_YELLOW
) (
  input  logic clk,
  input  logic rst,
  output logic Red,
  output logic Yellow,
  output logic Green
);

  localparam int CNT_W = cnt_width(
    RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES);

  state_t state;
  logic   legal;

  traffic_light_if #(.W(CNT_W)) tmr ();

  traffic_light_timer #(.W(CNT_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .tmr (tmr.slave)
  );

  assign legal = (state == RED)
              || (state == GREEN)
              || (state == YELLOW);

  always_comb begin
    tmr.limit = '0;
    case (state)
      RED:     tmr.limit = CNT_W'(RED_CYCLES - 1);
      GREEN:   tmr.limit = CNT_W'(GREEN_CYCLES - 1);
      YELLOW:  tmr.limit = CNT_W'(YELLOW_CYCLES - 1);
      default: tmr.limit = '0;
    endcase
  end

  // Restart the dwell on every phase change,
  // including recovery from the illegal code.
  assign tmr.clear = tmr.done || !legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RED;
    end else begin
      case (state)
        RED:
          if (tmr.done) state <= GREEN;
        GREEN:
          if (tmr.done) state <= YELLOW;
        YELLOW:
          if (tmr.done) state <= RED;
        default:
          state <= RED;
      endcase
    end
  end

  // Red covers the illegal code so one lamp is
  // always lit.
  assign Green  = (state == GREEN);
  assign Yellow = (state == YELLOW);
  assign Red    = !(Green || Yellow);

endmodule

// File: tb/tb_traffic_light.sv
// tb_traffic_light: directed checks of phase timing,
// async reset, 1-cycle phases and illegal recovery.
module tb_traffic_light;
  import traffic_light_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic Red, Yellow, Green;
  logic r1, y1, g1;
  logic [2:0] cur, prev;
  int checks = 0;
  int errors = 0;
  bit found;

  traffic_light dut (
    .clk    (clk),
    .rst    (rst),
    .Red    (Red),
    .Yellow (Yellow),
    .Green  (Green)
  );

  traffic_light #(
    .RED_CYCLES    (1),
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1)
  ) dut1 (
    .clk    (clk),
    .rst    (rst),
    .Red    (r1),
    .Yellow (y1),
    .Green  (g1)
  );

  traffic_light_if #(.W(4)) tif ();

  traffic_light_timer #(.W(4)) u_tmr (
    .clk (clk),
    .rst (rst),
    .tmr (tif.slave)
  );

  always #3 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  // {Red,Yellow,Green} expected n edges into a cycle
  function automatic logic [2:0] exp_lamp(
    input int n,
    input int r,
    input int g,
    input int y
  );
    int p;
    p = n % (r + g + y);
    if (p < r)          return 3'b100;
    else if (p < r + g) return 3'b001;
    else                return 3'b010;
  endfunction

  function automatic logic legal_step(
    input logic [2:0] a,
    input logic [2:0] b
  );
    return (a == b)
        || (a == 3'b100 && b == 3'b001)
        || (a == 3'b001 && b == 3'b010)
        || (a == 3'b010 && b == 3'b100);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    tif.clear = 1'b0;
    tif.limit = 4'd3;
    prev = 3'b100;

    #1;
    chk("rst_t1", {Red, Yellow, Green}, 3'b100);
    @(negedge clk);
    chk("rst_t6", {Red, Yellow, Green}, 3'b100);
    chk("rst_t6_fast", {r1, y1, g1}, 3'b100);
    #4 rst = 1'b0;

    @(negedge clk);
    for (int i = 0; i <= 83; i++) begin
      if (i > 0) @(negedge clk);
      cur = {Red, Yellow, Green};
      chk("seq_main", cur, exp_lamp(i, 10, 8, 3));
      chk("one_hot", $countones(cur), 1);
      chk("seq_fast", {r1, y1, g1},
          exp_lamp(i, 1, 1, 1));
      if (i > 0)
        chk("legal_step", legal_step(prev, cur), 1);
      prev = cur;
    end

    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      found = Green;
    end
    chk("find_green", found, 1);

    #1 rst = 1'b1;
    #1;
    chk("async_rst", {Red, Yellow, Green}, 3'b100);
    chk("async_cnt", dut.u_timer.cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("post_rst", {Red, Yellow, Green},
          exp_lamp(i, 10, 8, 3));
    end

    @(negedge clk);
    force dut.state = state_t'(2'b11);
    #1;
    chk("illegal_red", {Red, Yellow, Green}, 3'b100);
    #1 release dut.state;
    @(negedge clk);
    chk("recover_st", dut.state, RED);
    chk("recover_cnt", dut.u_timer.cnt, 0);
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("post_ill", {Red, Yellow, Green},
          exp_lamp(i, 10, 8, 3));
    end

    tif.clear = 1'b1;
    @(negedge clk);
    tif.clear = 1'b0;
    chk("tmr_c0", tif.done, 0);
    @(negedge clk);
    chk("tmr_c1", tif.done, 0);
    @(negedge clk);
    chk("tmr_c2", tif.done, 0);
    @(negedge clk);
    chk("tmr_c3", tif.done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
